// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR filter: one shared signed multiplier walks the taps one per
// cycle; valid/ready input, result held on the output until accepted.
module fir_mac_scheduler #(
    parameter int NTAPS = 4,
    parameter int W     = 8,
    parameter int ACC_W = 18,
    localparam int AW   = $clog2(NTAPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [W-1:0]     coef_data,
    output logic                    coef_err,
    input  logic                    in_valid,
    input  logic signed [W-1:0]     in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    input  logic                    out_ready,
    input  logic                    flush
);

    // Handshakes: a transfer happens on any rising edge where valid and ready are both
    // high; valid/data are held by the sender until then, and ready never waits on valid.

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_MAC, S_OUT} state_t;

    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    state_t                  state, state_next;
    logic signed [W-1:0]     x [NTAPS];
    logic signed [W-1:0]     c [NTAPS];
    logic signed [ACC_W-1:0] acc, sum;
    logic [AW-1:0]           k;
    logic signed [W-1:0]     tap_c, tap_x;
    logic signed [2*W-1:0]   prod;
    logic                    accept, last_tap, addr_ok, coef_ok;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_ready && in_valid;
    assign last_tap = (k == LAST);
    assign addr_ok  = ({1'b0, coef_addr} < (AW+1)'(NTAPS));
    // Coefficients are frozen while the MAC is walking them.
    assign coef_ok  = coef_we && addr_ok && (state != S_MAC);

    always_comb begin
        tap_c = '0;
        tap_x = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (k == AW'(i)) begin
                tap_c = c[i];
                tap_x = x[i];
            end
        end
    end

    assign prod = (2*W)'(tap_c) * (2*W)'(tap_x);
    assign sum  = acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_INIT: state_next = S_IDLE;
            S_IDLE: if (in_valid) state_next = S_MAC;
            S_MAC:  if (last_tap) state_next = S_OUT;
            S_OUT:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
            acc       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            coef_err  <= 1'b0;
        end else begin
            coef_err <= coef_we && !coef_ok;
            for (int i = 0; i < NTAPS; i++) begin
                if (coef_ok && coef_addr == AW'(i)) begin
                    c[i] <= coef_data;
                end
            end

            // Flush wins over the shift, so a same-edge sample lands in an empty line.
            if (accept || (in_ready && flush)) begin
                for (int i = 1; i < NTAPS; i++) begin
                    x[i] <= flush ? '0 : x[i-1];
                end
                x[0] <= accept ? in_data : '0;
            end

            if (accept) begin
                acc <= '0;
                k   <= '0;
            end else if (state == S_MAC) begin
                acc <= sum;
                k   <= last_tap ? '0 : k + AW'(1);
            end

            if (state == S_MAC && last_tap) begin
                out_data  <= sum;
                out_valid <= 1'b1;
            end else if (state == S_OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: timeline/dot-product model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_fir_mac_scheduler;

    localparam int NTAPS = 4;
    localparam int W     = 8;
    localparam int ACC_W = 18;
    localparam int AW    = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    coef_we = 1'b0;
    logic [AW-1:0]           coef_addr = '0;
    logic signed [W-1:0]     coef_data = '0;
    logic                    coef_err;
    logic                    in_valid = 1'b0;
    logic signed [W-1:0]     in_data = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_ready = 1'b1;
    logic                    flush = 1'b0;

    fir_mac_scheduler #(.NTAPS(NTAPS), .W(W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush(flush)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: coefficient and history arrays, a dot product, and edge-count timing.
    int               coefs [NTAPS];
    int               hist  [NTAPS];
    bit               m_init = 1'b1, m_idle = 1'b0, m_mac = 1'b0, m_hold = 1'b0;
    bit               exp_err = 1'b0;
    longint           m_result = 0;
    int               cyc = 0, due = 0, took_cyc = 0, n_took = 0;
    logic [ACC_W-1:0] exp_q [$];

    function automatic longint dot();
        longint s = 0;
        for (int i = 0; i < NTAPS; i++) s += longint'(coefs[i]) * longint'(hist[i]);
        return s;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                coefs[i] = 0;
                hist[i]  = 0;
            end
            m_init = 1'b1; m_idle = 1'b0; m_mac = 1'b0; m_hold = 1'b0; exp_err = 1'b0;
        end else begin
            cyc++;
            exp_err = coef_we && m_mac;
            if (coef_we && !m_mac) coefs[coef_addr] = int'(coef_data);
            if (m_init) begin
                m_init = 1'b0;
                m_idle = 1'b1;
            end else if (m_idle) begin
                if (flush) for (int i = 0; i < NTAPS; i++) hist[i] = 0;
                if (in_valid) begin
                    for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                    hist[0]  = int'(in_data);
                    m_idle   = 1'b0;
                    m_mac    = 1'b1;
                    due      = cyc + NTAPS;
                    took_cyc = cyc;
                    n_took++;
                end
            end else if (m_mac) begin
                if (cyc == due) begin
                    m_result = dot();
                    exp_q.push_back(ACC_W'(m_result));
                    m_mac  = 1'b0;
                    m_hold = 1'b1;
                end
            end else if (m_hold && out_ready) begin
                m_hold = 1'b0;
                m_idle = 1'b1;
            end
        end
    end

    longint got_q [$];
    bit     prev_ov = 1'b0;
    int     err_cnt = 0;

    initial forever begin
        @(negedge clk);
        check("in_ready", longint'(in_ready), longint'(m_idle));
        check("out_valid", longint'(out_valid), longint'(m_hold));
        check("coef_err", longint'(coef_err), longint'(exp_err));
        if (m_hold) check("out_data_hold", longint'(out_data), m_result);
        if (out_valid && !prev_ov) begin
            got_q.push_back(longint'(out_data));
            if (exp_q.size() == 0) check("unexpected_result", exp_q.size(), 1);
            else check("out_data_first", longint'(out_data), longint'($signed(exp_q.pop_front())));
            check("latency", cyc - took_cyc, NTAPS);
        end
        if (coef_err) err_cnt++;
        prev_ov = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = W'(d);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic load(input int c0, input int c1, input int c2, input int c3);
        write_coef(0, c0);
        write_coef(1, c1);
        write_coef(2, c2);
        write_coef(3, c3);
    endtask

    task automatic send(input int d, input bit fl);
        int start = n_took;
        bit done  = 1'b0;
        in_valid = 1'b1;
        in_data  = W'(d);
        flush    = fl;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            done = (n_took != start);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        if (!done) check("send_timeout", n_took - start, 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            done = m_idle;
        end
        if (!done) check("idle_timeout", longint'(m_idle), 1);
    endtask

    task automatic check_got(input string name, input int idx, input longint val);
        if (got_q.size() > idx) check(name, got_q[idx], val);
        else check(name, got_q.size(), idx + 1);
    endtask

    initial begin
        int err_base;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("reset_out_data", longint'(out_data), 0);
        check("reset_in_ready", longint'(in_ready), 0);
        #2 rst_n = 1'b1;
        tick();
        tick();

        // Impulse response
        load(1, 2, 3, 4);
        send(1, 1'b0); wait_idle();
        send(0, 1'b0); wait_idle();
        send(0, 1'b0); wait_idle();
        send(0, 1'b0); wait_idle();
        check_got("impulse0", 0, 1);
        check_got("impulse1", 1, 2);
        check_got("impulse2", 2, 3);
        check_got("impulse3", 3, 4);

        // Most-negative operands, growing sum
        load(-128, -128, -128, -128);
        for (int i = 0; i < 4; i++) begin
            send(-128, 1'b0);
            wait_idle();
        end
        check_got("extreme0", 4, 16384);
        check_got("extreme1", 5, 32768);
        check_got("extreme2", 6, 49152);
        check_got("extreme3", 7, 65536);

        // Backpressure: 10 held cycles with a stray sample offered
        load(1, 2, 3, 4);
        out_ready = 1'b0;
        send(2, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'sd99;
        repeat (14) tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_ready_after_pulse", longint'(in_ready), 1);
        check_got("backpressure", 8, -1150);

        // Coefficient write during MAC is dropped, then honoured in IDLE
        err_base = err_cnt;
        send(1, 1'b0);
        write_coef(2, 9);
        wait_idle();
        check_got("mac_write_result", 9, -891);
        check("mac_write_err_pulses", err_cnt - err_base, 1);
        write_coef(2, 9);
        send(0, 1'b0);
        wait_idle();
        check_got("idle_write_result", 10, -492);

        // Flush together with a new sample
        load(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            send(7, 1'b0);
            wait_idle();
        end
        check_got("sevens", 14, 28);
        send(5, 1'b1);
        wait_idle();
        check_got("flush_plus_sample", 15, 5);

        // Reset in the middle of the MAC
        send(3, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        tick();
        check("rst_in_ready_low", longint'(in_ready), 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("rst_in_ready_rise", longint'(in_ready), 1);
        check("rst_no_result", got_q.size(), 16);
        load(1, 1, 1, 1);
        send(6, 1'b0);
        wait_idle();
        check_got("rst_line_cleared", 16, 6);
        check("rst_result_count", got_q.size(), 17);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
